// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the CPU and a host port.
// Optional build macro DM_ARB_HOST_LOCK_EN adds host_lock, letting the host keep ownership across accesses.
module dm_arbiter #(
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned ACC_CYC = 1
) (
   input  logic              clk,
   input  logic              rst,
   // CPU load/store path
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_done,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   // host loader / debug port
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_gnt,
   output logic              host_done,
   output logic [DATA_W-1:0] host_rdata,
`ifdef DM_ARB_HOST_LOCK_EN
   input  logic              host_lock,
`endif
   // data memory side
   output logic [ADDR_W-1:0] dm_addr,
   output logic [DATA_W-1:0] dm_wdata,
   output logic              dm_we,
   input  logic [DATA_W-1:0] dm_rdata
);

   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACC_CYC - 1);

   typedef enum logic {IDLE, ACC} state_t;
   typedef enum logic {OWN_CPU, OWN_HOST} own_t;

   if (ACC_CYC < 1 || ACC_CYC > 15) begin : g_bad_acc_cyc
      $error("dm_arbiter: ACC_CYC must be in 1..15");
   end

   state_t            state;
   state_t            state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_nxt;
   own_t              last_gnt;
   own_t              owner;
   own_t              grant_own;
   logic              lat_we;

   logic              cpu_elig;
   logic              host_elig;
   logic              grant;
   logic              finish;
   logic              we_nxt;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   assign cpu_stall = cpu_req & ~cpu_done;

   // Arbitration and access sequencing
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      grant     = 1'b0;
      grant_own = OWN_CPU;
      finish    = 1'b0;
      cpu_elig  = cpu_req & ~cpu_done;
      host_elig = host_req & ~host_done;
`ifdef DM_ARB_HOST_LOCK_EN
      // A locking host that owned the last access keeps the CPU out until it releases.
      if (host_lock && (last_gnt == OWN_HOST)) begin
         cpu_elig = 1'b0;
      end
`endif
      case (state)
         IDLE: begin
            if (cpu_elig && host_elig) begin
               grant     = 1'b1;
               grant_own = (last_gnt == OWN_CPU) ? OWN_HOST : OWN_CPU;
            end else if (cpu_elig) begin
               grant     = 1'b1;
               grant_own = OWN_CPU;
            end else if (host_elig) begin
               grant     = 1'b1;
               grant_own = OWN_HOST;
            end
            if (grant) begin
               state_nxt = ACC;
               cnt_nxt   = CNT_LOAD;
            end
         end
         ACC: begin
            if (cnt != '0) begin
               cnt_nxt = cnt - CNT_W'(1);
            end else begin
               finish    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase

      sel_we    = (grant_own == OWN_HOST) ? host_we    : cpu_we;
      sel_addr  = (grant_own == OWN_HOST) ? host_addr  : cpu_addr;
      sel_wdata = (grant_own == OWN_HOST) ? host_wdata : cpu_wdata;

      // dm_we is registered: raise it on the edge that enters the cnt==0 cycle
      we_nxt = (grant && (ACC_CYC == 1) && sel_we) ||
               ((state == ACC) && (cnt == CNT_W'(1)) && lat_we);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         last_gnt   <= OWN_HOST;
         owner      <= OWN_CPU;
         lat_we     <= 1'b0;
         dm_addr    <= '0;
         dm_wdata   <= '0;
         dm_we      <= 1'b0;
         cpu_gnt    <= 1'b0;
         host_gnt   <= 1'b0;
         cpu_done   <= 1'b0;
         host_done  <= 1'b0;
         cpu_rdata  <= '0;
         host_rdata <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         dm_we     <= we_nxt;
         cpu_gnt   <= grant && (grant_own == OWN_CPU);
         host_gnt  <= grant && (grant_own == OWN_HOST);
         cpu_done  <= finish && (owner == OWN_CPU);
         host_done <= finish && (owner == OWN_HOST);
         if (grant) begin
            owner    <= grant_own;
            last_gnt <= grant_own;
            lat_we   <= sel_we;
            dm_addr  <= sel_addr;
            dm_wdata <= sel_wdata;
         end
         // Reads land in the owner's rdata; writes leave it untouched
         if (finish && !lat_we) begin
            if (owner == OWN_CPU) begin
               cpu_rdata <= dm_rdata;
            end else begin
               host_rdata <= dm_rdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed self-checking bench for dm_arbiter: instance a uses ACC_CYC=1, instance b uses ACC_CYC=4.
module tb_dm_arbiter;

   localparam int unsigned AW = 16;
   localparam int unsigned DW = 32;
`ifdef DM_ARB_HOST_LOCK_EN
   localparam int EXP_NH = 3;
`else
   localparam int EXP_NH = 1;
`endif

   logic clk;
   logic rst;

   logic          a_cpu_req, a_cpu_we, a_cpu_gnt, a_cpu_done, a_cpu_stall;
   logic [AW-1:0] a_cpu_addr;
   logic [DW-1:0] a_cpu_wdata, a_cpu_rdata;
   logic          a_host_req, a_host_we, a_host_gnt, a_host_done, a_host_lock;
   logic [AW-1:0] a_host_addr;
   logic [DW-1:0] a_host_wdata, a_host_rdata;
   logic [AW-1:0] a_dm_addr;
   logic [DW-1:0] a_dm_wdata, a_dm_rdata;
   logic          a_dm_we;

   logic          b_cpu_req, b_cpu_we, b_cpu_gnt, b_cpu_done, b_cpu_stall;
   logic [AW-1:0] b_cpu_addr;
   logic [DW-1:0] b_cpu_wdata, b_cpu_rdata;
   logic          b_host_req, b_host_we, b_host_gnt, b_host_done, b_host_lock;
   logic [AW-1:0] b_host_addr;
   logic [DW-1:0] b_host_wdata, b_host_rdata;
   logic [AW-1:0] b_dm_addr;
   logic [DW-1:0] b_dm_wdata, b_dm_rdata;
   logic          b_dm_we;

   logic [DW-1:0] mem_a [0:255];
   logic [DW-1:0] mem_b [0:255];
   int a_we_cnt = 0;
   int b_we_cnt = 0;

   int n_chk  = 0;
   int n_fail = 0;

   dm_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACC_CYC(1)) u_dut_a (
      .clk(clk), .rst(rst),
      .cpu_req(a_cpu_req), .cpu_we(a_cpu_we), .cpu_addr(a_cpu_addr), .cpu_wdata(a_cpu_wdata),
      .cpu_gnt(a_cpu_gnt), .cpu_done(a_cpu_done), .cpu_rdata(a_cpu_rdata), .cpu_stall(a_cpu_stall),
      .host_req(a_host_req), .host_we(a_host_we), .host_addr(a_host_addr), .host_wdata(a_host_wdata),
      .host_gnt(a_host_gnt), .host_done(a_host_done), .host_rdata(a_host_rdata),
`ifdef DM_ARB_HOST_LOCK_EN
      .host_lock(a_host_lock),
`endif
      .dm_addr(a_dm_addr), .dm_wdata(a_dm_wdata), .dm_we(a_dm_we), .dm_rdata(a_dm_rdata)
   );

   dm_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACC_CYC(4)) u_dut_b (
      .clk(clk), .rst(rst),
      .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
      .cpu_gnt(b_cpu_gnt), .cpu_done(b_cpu_done), .cpu_rdata(b_cpu_rdata), .cpu_stall(b_cpu_stall),
      .host_req(b_host_req), .host_we(b_host_we), .host_addr(b_host_addr), .host_wdata(b_host_wdata),
      .host_gnt(b_host_gnt), .host_done(b_host_done), .host_rdata(b_host_rdata),
`ifdef DM_ARB_HOST_LOCK_EN
      .host_lock(b_host_lock),
`endif
      .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata), .dm_we(b_dm_we), .dm_rdata(b_dm_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory models: combinational read, write on rising edge
   always_comb a_dm_rdata = mem_a[a_dm_addr[7:0]];
   always_comb b_dm_rdata = mem_b[b_dm_addr[7:0]];

   always @(posedge clk) begin
      if (a_dm_we) begin
         mem_a[a_dm_addr[7:0]] <= a_dm_wdata;
         a_we_cnt <= a_we_cnt + 1;
      end
      if (b_dm_we) begin
         mem_b[b_dm_addr[7:0]] <= b_dm_wdata;
         b_we_cnt <= b_we_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   initial begin
      int s;
      int nh;
      int host_left;
      logic cpu_g;
      logic cpu_fin;
      logic [3:0] exp_pat [0:7];

      for (int i = 0; i < 256; i++) begin
         mem_a[i] = '0;
         mem_b[i] = '0;
      end
      rst = 1'b1;
      a_cpu_req = 0; a_cpu_we = 0; a_cpu_addr = '0; a_cpu_wdata = '0;
      a_host_req = 0; a_host_we = 0; a_host_addr = '0; a_host_wdata = '0; a_host_lock = 0;
      b_cpu_req = 0; b_cpu_we = 0; b_cpu_addr = '0; b_cpu_wdata = '0;
      b_host_req = 0; b_host_we = 0; b_host_addr = '0; b_host_wdata = '0; b_host_lock = 0;

      // reset values
      repeat (2) @(negedge clk);
      chk("rst_cpu_gnt", a_cpu_gnt, 0);
      chk("rst_host_done", a_host_done, 0);
      chk("rst_dm_we", a_dm_we, 0);
      chk("rst_dm_addr", a_dm_addr, 0);
      chk("rst_cpu_rdata", a_cpu_rdata, 0);
      chk("rst_cpu_stall", a_cpu_stall, 0);
      rst = 1'b0;

      // CPU read, ACC_CYC=1
      mem_a[5] = 32'hDEADBEEF;
      @(negedge clk);
      a_cpu_req = 1; a_cpu_we = 0; a_cpu_addr = 16'd5;
      #1 chk("rd_stall_t", a_cpu_stall, 1);
      @(negedge clk);
      chk("rd_gnt", a_cpu_gnt, 1);
      chk("rd_dm_addr", a_dm_addr, 5);
      chk("rd_stall_t1", a_cpu_stall, 1);
      chk("rd_no_done_early", a_cpu_done, 0);
      @(negedge clk);
      chk("rd_done", a_cpu_done, 1);
      chk("rd_rdata", a_cpu_rdata, 32'hDEADBEEF);
      chk("rd_stall_done", a_cpu_stall, 0);
      chk("rd_gnt_pulse", a_cpu_gnt, 0);
      a_cpu_req = 0;
      @(negedge clk);
      chk("rd_done_pulse", a_cpu_done, 0);

      // host write then CPU read of the same word
      s = a_we_cnt;
      a_host_req = 1; a_host_we = 1; a_host_addr = 16'd3; a_host_wdata = 32'h42;
      @(negedge clk);
      chk("hw_gnt", a_host_gnt, 1);
      chk("hw_dm_we", a_dm_we, 1);
      chk("hw_dm_addr", a_dm_addr, 3);
      @(negedge clk);
      chk("hw_done", a_host_done, 1);
      chk("hw_we_off", a_dm_we, 0);
      a_host_req = 0;
      a_cpu_req = 1; a_cpu_we = 0; a_cpu_addr = 16'd3;
      @(negedge clk);
      chk("hr_cpu_gnt", a_cpu_gnt, 1);
      @(negedge clk);
      chk("hr_cpu_done", a_cpu_done, 1);
      chk("hr_cpu_rdata", a_cpu_rdata, 32'h42);
      a_cpu_req = 0;
      chk("hr_we_pulses", a_we_cnt - s, 1);
      chk("hr_host_rdata_kept", a_host_rdata, 0);

      // reset in the middle of a write access
      @(negedge clk);
      s = a_we_cnt;
      a_cpu_req = 1; a_cpu_we = 1; a_cpu_addr = 16'd9; a_cpu_wdata = 32'hAA;
      @(negedge clk);
      chk("ra_gnt", a_cpu_gnt, 1);
      chk("ra_we_before", a_dm_we, 1);
      rst = 1'b1;
      #1;
      chk("ra_we_async", a_dm_we, 0);
      chk("ra_gnt_async", a_cpu_gnt, 0);
      @(negedge clk);
      chk("ra_no_done", a_cpu_done, 0);
      chk("ra_no_write", a_we_cnt - s, 0);
      chk("ra_mem", mem_a[9], 0);
      a_cpu_req = 0; a_cpu_we = 0;
      rst = 1'b0;

      // contention from reset: CPU first, then alternate, 2 cycles each
      exp_pat[0] = 4'b1000; exp_pat[1] = 4'b0010; exp_pat[2] = 4'b0100; exp_pat[3] = 4'b0001;
      exp_pat[4] = 4'b1000; exp_pat[5] = 4'b0010; exp_pat[6] = 4'b0100; exp_pat[7] = 4'b0001;
      a_cpu_req = 1; a_cpu_we = 0; a_cpu_addr = 16'd5;
      a_host_req = 1; a_host_we = 0; a_host_addr = 16'd3;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk($sformatf("rr_cycle%0d", i), {a_cpu_gnt, a_host_gnt, a_cpu_done, a_host_done}, exp_pat[i]);
         if (i == 7) begin
            a_cpu_req = 0;
            a_host_req = 0;
         end else begin
            a_cpu_req = ~a_cpu_done;
            a_host_req = ~a_host_done;
         end
      end
      chk("rr_cpu_rdata", a_cpu_rdata, 32'hDEADBEEF);
      chk("rr_host_rdata", a_host_rdata, 32'h42);

      // ACC_CYC=4 write on instance b
      @(negedge clk);
      s = b_we_cnt;
      b_cpu_req = 1; b_cpu_we = 1; b_cpu_addr = 16'd7; b_cpu_wdata = 32'h77;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk($sformatf("a4_gnt%0d", i), b_cpu_gnt, (i == 0) ? 1 : 0);
         chk($sformatf("a4_we%0d", i), b_dm_we, (i == 3) ? 1 : 0);
         chk($sformatf("a4_done%0d", i), b_cpu_done, (i == 4) ? 1 : 0);
         if (i < 4) chk($sformatf("a4_addr%0d", i), b_dm_addr, 7);
         if (b_cpu_done) b_cpu_req = 0;
      end
      chk("a4_we_pulses", b_we_cnt - s, 1);
      chk("a4_mem", mem_b[7], 32'h77);

      // host lock: three host writes against a waiting CPU read
      @(negedge clk);
      host_left = 3;
      nh = 0;
      cpu_g = 0;
      cpu_fin = 0;
      a_host_req = 1; a_host_we = 1; a_host_addr = 16'd16; a_host_wdata = 32'd16; a_host_lock = 1;
      for (int i = 0; i < 40 && !(cpu_fin && host_left == 0); i++) begin
         @(negedge clk);
         if (a_host_gnt && !cpu_g) nh++;
         if (a_cpu_gnt) cpu_g = 1;
         if (a_cpu_done) begin
            chk("lk_cpu_rdata", a_cpu_rdata, 32'd16);
            cpu_fin = 1;
            a_cpu_req = 0;
         end else if (!cpu_fin) begin
            a_cpu_req = 1; a_cpu_we = 0; a_cpu_addr = 16'd16;
         end
         if (a_host_done) begin
            host_left--;
            a_host_req = 0;
            a_host_lock = (host_left != 0);
         end else begin
            a_host_req = (host_left != 0);
            a_host_addr = AW'(19 - host_left);
            a_host_wdata = DW'(19 - host_left);
         end
      end
      chk("lk_complete", (cpu_fin && host_left == 0), 1);
      chk("lk_host_before_cpu", nh, EXP_NH);
      chk("lk_mem16", mem_a[16], 32'd16);
      chk("lk_mem17", mem_a[17], 32'd17);
      chk("lk_mem18", mem_a[18], 32'd18);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
